reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined core. It replaces the single-write, two-read register file.
- Adds configurable read/write port counts, same-cycle write-to-read bypass, and a per-register busy scoreboard so decode can detect read-after-write hazards.
- Sits between decode (reads, issue marking) and writeback (writes, busy clearing).

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/reg_file_mp.sv | 101 ++++++++++
 tb/tb_reg_file_mp.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Imported by the register file top and its scoreboard.
package reg_file_pkg;

    localparam int ZERO_REG      = 0;
    localparam int DEFAULT_XLEN  = 64;
    localparam int DEFAULT_NREGS = 32;

    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush/reset clear all.
// Register 0 can never become busy.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NUM_WR = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy_vec
);

    localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        // A younger producer issued this cycle keeps the register pending.
        if (issue_en && issue_rd != R0) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[R0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a
// busy scoreboard for read-after-write hazard detection in decode.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_rd,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy_vec
);

    localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [AW-1:0]   wa     [NUM_WR];
    logic [XLEN-1:0] wd     [NUM_WR];

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j] = wr_addr[j*AW +: AW];
        assign wd[j] = wr_data[j*XLEN +: XLEN];
    end

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wa[j] != R0) begin
                regs_d[wa[j]] = wd[j];
            end
        end
        regs_d[R0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] val;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            hit = 1'b0;
            val = regs_q[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wa[j] == ra) begin
                        hit = 1'b1;
                        val = wd[j];
                    end
                end
            end
            if (ra == R0) begin
                hit = 1'b0;
                val = '0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = val;
        assign rd_busy[i] = busy_vec[ra] && !hit && (ra != R0);
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: dual-write bypassing instance (a) and
// single-write non-bypassing instance (b).
module tb_reg_file_mp;

    logic clk;
    logic reset;

    logic [9:0]   a_rd_addr;
    logic [127:0] a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [1:0]   a_wr_en;
    logic [9:0]   a_wr_addr;
    logic [127:0] a_wr_data;
    logic         a_issue_en;
    logic [4:0]   a_issue_rd;
    logic         a_flush;
    logic [31:0]  a_busy;

    logic [9:0]   b_rd_addr;
    logic [127:0] b_rd_data;
    logic [1:0]   b_rd_busy;
    logic [0:0]   b_wr_en;
    logic [4:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_issue_en;
    logic [4:0]   b_issue_rd;
    logic         b_flush;
    logic [31:0]  b_busy;

    int pass_cnt;
    int total;

    reg_file_mp #(
        .XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)
    ) dut_a (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .rd_busy  (a_rd_busy),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .issue_en (a_issue_en),
        .issue_rd (a_issue_rd),
        .flush    (a_flush),
        .busy_vec (a_busy)
    );

    reg_file_mp #(
        .XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_busy  (b_rd_busy),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .issue_en (b_issue_en),
        .issue_rd (b_issue_rd),
        .flush    (b_flush),
        .busy_vec (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        a_wr_en    = '0;
        a_wr_addr  = '0;
        a_wr_data  = '0;
        a_issue_en = 1'b0;
        a_issue_rd = '0;
        a_flush    = 1'b0;
        b_wr_en    = '0;
        b_wr_addr  = '0;
        b_wr_data  = '0;
        b_issue_en = 1'b0;
        b_issue_rd = '0;
        b_flush    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        a_rd_addr = '0;
        b_rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            a_rd_addr = {5'(k), 5'(k)};
            b_rd_addr = {5'(k), 5'(k)};
            #1;
            total++;
            if (a_rd_data !== 128'd0 || a_rd_busy !== 2'b00)
                $display("FAIL rst_a r%0d: got %h/%b want 0/00", k, a_rd_data, a_rd_busy);
            else pass_cnt++;
            total++;
            if (b_rd_data !== 128'd0 || b_rd_busy !== 2'b00)
                $display("FAIL rst_b r%0d: got %h/%b want 0/00", k, b_rd_data, b_rd_busy);
            else pass_cnt++;
        end
        total++;
        if (a_busy !== 32'd0 || b_busy !== 32'd0)
            $display("FAIL rst_busy: got %h %h want 0 0", a_busy, b_busy);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [63:0] v;
        v = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        a_wr_en = 2'b01;
        a_wr_addr = {5'd0, 5'd5};
        a_wr_data = {64'd0, v};
        a_rd_addr = {5'd5, 5'd0};
        b_wr_en = 1'b1;
        b_wr_addr = 5'd5;
        b_wr_data = v;
        b_rd_addr = {5'd5, 5'd0};
        #1;
        total++;
        if (a_rd_data[127:64] !== v)
            $display("FAIL byp_same_cycle: got %h want %h", a_rd_data[127:64], v);
        else pass_cnt++;
        total++;
        if (b_rd_data[127:64] !== 64'd0)
            $display("FAIL nobyp_same_cycle: got %h want 0", b_rd_data[127:64]);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (b_rd_data[127:64] !== v)
            $display("FAIL nobyp_next_cycle: got %h want %h", b_rd_data[127:64], v);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (a_rd_data[127:64] !== v)
            $display("FAIL byp_stored: got %h want %h", a_rd_data[127:64], v);
        else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        a_wr_en = 2'b01;
        a_wr_addr = {5'd0, 5'd0};
        a_wr_data = {64'd0, 64'h1234};
        a_rd_addr = {5'd0, 5'd0};
        a_issue_en = 1'b1;
        a_issue_rd = 5'd0;
        #1;
        total++;
        if (a_rd_data[63:0] !== 64'd0)
            $display("FAIL r0_bypass: got %h want 0", a_rd_data[63:0]);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (a_rd_data[63:0] !== 64'd0 || a_rd_busy[0] !== 1'b0)
            $display("FAIL r0_read: got %h/%b want 0/0", a_rd_data[63:0], a_rd_busy[0]);
        else pass_cnt++;
        total++;
        if (a_busy[0] !== 1'b0)
            $display("FAIL r0_busy: got %b want 0", a_busy[0]);
        else pass_cnt++;
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        a_wr_en = 2'b11;
        a_wr_addr = {5'd7, 5'd7};
        a_wr_data = {64'hBB, 64'hAA};
        a_rd_addr = {5'd0, 5'd7};
        #1;
        total++;
        if (a_rd_data[63:0] !== 64'hBB)
            $display("FAIL dual_bypass: got %h want bb", a_rd_data[63:0]);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (a_rd_data[63:0] !== 64'hBB)
            $display("FAIL dual_stored: got %h want bb", a_rd_data[63:0]);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        a_issue_en = 1'b1;
        a_issue_rd = 5'd3;
        a_rd_addr = {5'd0, 5'd3};
        #1;
        total++;
        if (a_busy[3] !== 1'b0 || a_rd_busy[0] !== 1'b0)
            $display("FAIL sb_issue_t: got %b/%b want 0/0", a_busy[3], a_rd_busy[0]);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (a_busy[3] !== 1'b1 || a_rd_busy[0] !== 1'b1)
            $display("FAIL sb_issue_t1: got %b/%b want 1/1", a_busy[3], a_rd_busy[0]);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        a_wr_en = 2'b01;
        a_wr_addr = {5'd0, 5'd3};
        a_wr_data = {64'd0, 64'h33};
        #1;
        total++;
        if (a_rd_busy[0] !== 1'b0 || a_busy[3] !== 1'b1)
            $display("FAIL sb_wb_t3: got %b/%b want 0/1", a_rd_busy[0], a_busy[3]);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (a_busy[3] !== 1'b0)
            $display("FAIL sb_wb_t4: got %b want 0", a_busy[3]);
        else pass_cnt++;
        @(negedge clk);
        idle();
        a_issue_en = 1'b1;
        a_issue_rd = 5'd3;
        a_wr_en = 2'b10;
        a_wr_addr = {5'd3, 5'd0};
        a_wr_data = {64'h44, 64'd0};
        @(negedge clk);
        idle();
        #1;
        total++;
        if (a_busy[3] !== 1'b1 || a_rd_busy[0] !== 1'b1)
            $display("FAIL sb_issue_wb: got %b/%b want 1/1", a_busy[3], a_rd_busy[0]);
        else pass_cnt++;
        total++;
        if (a_rd_data[63:0] !== 64'h44)
            $display("FAIL sb_issue_wb_data: got %h want 44", a_rd_data[63:0]);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] exp_busy;
        exp_busy = (32'd1 << 3) | (32'd1 << 9) | (32'd1 << 12);
        @(negedge clk);
        a_issue_en = 1'b1;
        a_issue_rd = 5'd3;
        @(negedge clk);
        a_issue_rd = 5'd9;
        @(negedge clk);
        a_issue_rd = 5'd12;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (a_busy !== exp_busy)
            $display("FAIL flush_pre: got %h want %h", a_busy, exp_busy);
        else pass_cnt++;
        a_flush = 1'b1;
        a_wr_en = 2'b01;
        a_wr_addr = {5'd0, 5'd9};
        a_wr_data = {64'd0, 64'h99};
        @(negedge clk);
        idle();
        a_rd_addr = {5'd12, 5'd9};
        #1;
        total++;
        if (a_busy !== 32'd0 || a_rd_busy !== 2'b00)
            $display("FAIL flush_busy: got %h/%b want 0/00", a_busy, a_rd_busy);
        else pass_cnt++;
        total++;
        if (a_rd_data[63:0] !== 64'h99)
            $display("FAIL flush_wr: got %h want 99", a_rd_data[63:0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_issue_en = 1'b1;
        a_issue_rd = 5'd5;
        @(negedge clk);
        a_issue_rd = 5'd11;
        a_wr_en = 2'b01;
        a_wr_addr = {5'd0, 5'd10};
        a_wr_data = {64'd0, 64'hA5A5};
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle();
        a_rd_addr = {5'd5, 5'd10};
        b_rd_addr = {5'd0, 5'd5};
        #1;
        total++;
        if (a_busy !== 32'd0 || b_busy !== 32'd0)
            $display("FAIL rmid_busy: got %h %h want 0 0", a_busy, b_busy);
        else pass_cnt++;
        total++;
        if (a_rd_data !== 128'd0)
            $display("FAIL rmid_a_r10_r5: got %h want 0", a_rd_data);
        else pass_cnt++;
        total++;
        if (b_rd_data[63:0] !== 64'd0)
            $display("FAIL rmid_b_r5: got %h want 0", b_rd_data[63:0]);
        else pass_cnt++;
        a_rd_addr = {5'd9, 5'd7};
        #1;
        total++;
        if (a_rd_data !== 128'd0)
            $display("FAIL rmid_a_r7_r9: got %h want 0", a_rd_data);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total = 0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_dual_write();
        test_scoreboard();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
